// File: rtl/hdmi_pattern_axis_src.sv
// hdmi_pattern_axis_src: AXI-Stream test-pattern video source, one TLAST-terminated packet per line
module hdmi_pattern_axis_src #(
  parameter int C_M_AXIS_TDATA_WIDTH = 24,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int LINE_GAP = 0
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            enable,
  input  logic [1:0]                      pattern_sel,
  input  logic [23:0]                     solid_rgb,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TUSER,
  output logic                            busy,
  output logic                            frame_done
);
  localparam int XW = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
  localparam int YW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  localparam int BW = H_ACTIVE / 8;
  localparam int BCW = BW > 1 ? $clog2(BW) : 1;
  localparam int GW = LINE_GAP > 1 ? $clog2(LINE_GAP) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BW - 1);
  localparam logic [GW-1:0] G_LAST = GW'(LINE_GAP > 0 ? LINE_GAP - 1 : 0);
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  state_t state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [BCW-1:0] bc, bc_n;
  logic [2:0] bi, bi_n;
  logic [GW-1:0] gc, gc_n;
  logic [1:0] pat, pat_n;
  logic [23:0] sol, sol_n, pix;
  logic xfer, eol, eof, start, load, valid_n, fd_n, x_b5, y_b5;
  always_comb begin
    xfer = M_AXIS_TVALID && M_AXIS_TREADY;
    eol = xfer && x == X_LAST;
    eof = eol && y == Y_LAST;
    start = (state == IDLE) ? enable : eof && enable;
    state_n = state;
    x_n = x;
    y_n = y;
    bc_n = bc;
    bi_n = bi;
    gc_n = gc;
    pat_n = pat;
    sol_n = sol;
    valid_n = M_AXIS_TVALID;
    load = 1'b0;
    fd_n = eof;
    if (start) begin
      state_n = ACTIVE;
      pat_n = pattern_sel;
      sol_n = solid_rgb;
      x_n = '0;
      y_n = '0;
      bc_n = '0;
      bi_n = '0;
      valid_n = 1'b1;
      load = 1'b1;
    end else if (eof) begin
      state_n = IDLE;
      valid_n = 1'b0;
      x_n = '0;
      y_n = '0;
    end else if (eol) begin
      x_n = '0;
      y_n = y + 1'b1;
      bc_n = '0;
      bi_n = '0;
      if (LINE_GAP > 0) begin
        state_n = GAP;
        gc_n = '0;
        valid_n = 1'b0;
      end else load = 1'b1;
    end else if (xfer) begin
      x_n = x + 1'b1;
      bc_n = (bc == BC_LAST) ? '0 : bc + 1'b1;
      bi_n = (bc == BC_LAST && bi != 3'd7) ? bi + 3'd1 : bi;
      load = 1'b1;
    end else if (state == GAP) begin
      if (gc == G_LAST) begin
        state_n = ACTIVE;
        valid_n = 1'b1;
        load = 1'b1;
      end else gc_n = gc + 1'b1;
    end
    x_b5 = |(32'(x_n) & 32'h20);
    y_b5 = |(32'(y_n) & 32'h20);
    pix = pat_n == 2'd0 ? BARS[bi_n] :
          pat_n == 2'd1 ? {3{8'(x_n)}} :
          pat_n == 2'd2 ? sol_n :
          (x_b5 ^ y_b5) ? 24'hFFFFFF : 24'h000000;
  end
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      bc <= '0;
      bi <= '0;
      gc <= '0;
      pat <= '0;
      sol <= '0;
      M_AXIS_TDATA <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST <= 1'b0;
      M_AXIS_TUSER <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      bc <= bc_n;
      bi <= bi_n;
      gc <= gc_n;
      pat <= pat_n;
      sol <= sol_n;
      M_AXIS_TVALID <= valid_n;
      frame_done <= fd_n;
      if (load) begin
        M_AXIS_TDATA <= pix;
        M_AXIS_TLAST <= x_n == X_LAST;
        M_AXIS_TUSER <= x_n == '0 && y_n == '0;
      end
    end
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_hdmi_pattern_axis_src.sv
// tb_hdmi_pattern_axis_src: self-checking bench for the AXI-Stream pattern source
`timescale 1ns/1ps
module tb_hdmi_pattern_axis_src;
  localparam int H = 16;
  localparam int V = 4;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int passed = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic logic [23:0] ref_pix(input int p, input logic [23:0] s, input int x, input int y, input int h);
    case (p)
      0: return BARS[x / (h / 8)];
      1: return {3{8'(x % 256)}};
      2: return s;
      default: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction
  logic rst, en, tready, b_rst;
  logic [1:0] psel;
  logic [23:0] solid;
  logic [23:0] tdata, b_data, c_data;
  logic tvalid, tlast, tuser, busy, fdone;
  logic b_valid, b_last, b_user, b_busy, b_fd;
  logic c_valid, c_last, c_user, c_busy, c_fd;
  hdmi_pattern_axis_src #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_GAP(0)) dut_a (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .enable(en), .pattern_sel(psel), .solid_rgb(solid),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast),
    .M_AXIS_TUSER(tuser), .busy(busy), .frame_done(fdone));
  hdmi_pattern_axis_src #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_GAP(2)) dut_b (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(b_rst), .enable(1'b1), .pattern_sel(2'd2), .solid_rgb(24'h123456),
    .M_AXIS_TDATA(b_data), .M_AXIS_TVALID(b_valid), .M_AXIS_TREADY(1'b1), .M_AXIS_TLAST(b_last),
    .M_AXIS_TUSER(b_user), .busy(b_busy), .frame_done(b_fd));
  hdmi_pattern_axis_src #(.H_ACTIVE(128), .V_ACTIVE(64), .LINE_GAP(0)) dut_c (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(b_rst), .enable(1'b1), .pattern_sel(2'd3), .solid_rgb(24'h0),
    .M_AXIS_TDATA(c_data), .M_AXIS_TVALID(c_valid), .M_AXIS_TREADY(1'b1), .M_AXIS_TLAST(c_last),
    .M_AXIS_TUSER(c_user), .busy(c_busy), .frame_done(c_fd));
  bit chk_on, m_rst, m_act, m_fd;
  int ex, ey, mpat, frames;
  logic [23:0] msol, pd;
  logic pv, pr, pl;
  logic [23:0] cap [8][64];
  task automatic start_frame();
    m_act = 1;
    ex = 0;
    ey = 0;
    mpat = int'(psel);
    msol = solid;
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_valid", tvalid, m_act);
      chk("a_busy", busy, m_act);
      chk("a_frame_done", fdone, m_fd);
      if (m_rst) begin
        chk("a_rst_data", tdata, 0);
        chk("a_rst_last", tlast, 0);
        chk("a_rst_user", tuser, 0);
      end
      if (m_act) begin
        chk("a_data", tdata, ref_pix(mpat, msol, ex, ey, H));
        chk("a_last", tlast, ex == H - 1);
        chk("a_user", tuser, ex == 0 && ey == 0);
      end
      if (pv && !pr && !m_rst) begin
        chk("a_hold_data", tdata, pd);
        chk("a_hold_last", tlast, pl);
      end
    end
    pv = tvalid;
    pr = tready;
    pd = tdata;
    pl = tlast;
    m_fd = 0;
    m_rst = 0;
    if (rst) begin
      chk_on = 1;
      m_rst = 1;
      m_act = 0;
    end else if (m_act && tready) begin
      if (frames < 8) cap[frames][ey * H + ex] = tdata;
      if (ex == H - 1 && ey == V - 1) begin
        m_fd = 1;
        frames++;
        if (en) start_frame();
        else m_act = 0;
      end else if (ex == H - 1) begin
        ex = 0;
        ey++;
      end else ex++;
    end else if (!m_act && en) start_frame();
  end
  int b_line, gz;
  bit armed;
  int gaps [8];
  always @(negedge clk) if (!b_rst) begin
    if (b_valid) chk("b_data", b_data, 24'h123456);
    if (armed) begin
      if (b_valid) begin
        if (b_line < 8) gaps[b_line] = gz;
        b_line++;
        armed = 0;
      end else gz++;
    end
    if (b_valid && b_last) begin
      armed = 1;
      gz = 0;
    end
  end
  int cx, cy;
  bit c_done;
  logic [23:0] ccap [4];
  logic c_tu0;
  always @(negedge clk) if (!b_rst && !c_done && c_valid) begin
    if (cx == 32 && cy == 0) ccap[0] = c_data;
    if (cx == 0 && cy == 32) ccap[1] = c_data;
    if (cx == 32 && cy == 32) ccap[2] = c_data;
    if (cx == 0 && cy == 0) begin
      ccap[3] = c_data;
      c_tu0 = c_user;
    end
    if (cx == 127) begin
      chk("c_last", c_last, 1);
      cx = 0;
      if (cy == 63) c_done = 1;
      else cy++;
    end else cx++;
  end
  task automatic wait_frames(input int n);
    for (int i = 0; i < 3000 && frames < n; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_frames", frames, n);
  endtask
  task automatic wait_beat(input int f, input int b);
    for (int i = 0; i < 3000 && !(frames == f && m_act && ey * H + ex >= b); i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_beat", frames == f && ey * H + ex >= b, 1);
  endtask
  initial begin
    rst = 1;
    b_rst = 1;
    en = 0;
    psel = 2'd0;
    solid = 24'h0;
    tready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    b_rst = 0;
    en = 1;
    wait_frames(1);
    chk("t1_next_tuser", tuser, 1);
    chk("t1_frame_done", fdone, 1);
    chk("t1_px0", cap[0][0], 24'hFFFFFF);
    chk("t1_px3", cap[0][3], 24'hFFFF00);
    chk("t1_px4", cap[0][4], 24'h00FFFF);
    chk("t1_px15", cap[0][15], 24'h000000);
    chk("t1_px16", cap[0][16], 24'hFFFFFF);
    psel = 2'd1;
    for (int i = 0; i < 3000 && frames < 3; i++) begin
      @(posedge clk);
      #1;
      tready = 1'($urandom_range(0, 1));
    end
    tready = 1;
    chk("t2_frames", frames, 3);
    chk("t2_px5", cap[2][5], 24'h050505);
    chk("t2_px47", cap[2][47], 24'h0F0F0F);
    wait_beat(3, 20);
    psel = 2'd2;
    en = 0;
    wait_frames(4);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_valid", tvalid, 0);
    chk("t4_px21", cap[3][21], 24'h050505);
    chk("t4_px63", cap[3][63], 24'h0F0F0F);
    psel = 2'd0;
    en = 1;
    wait_beat(4, 30);
    tready = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    tready = 1;
    chk("t5_valid", tvalid, 0);
    chk("t5_busy", busy, 0);
    wait_frames(5);
    en = 0;
    chk("t5_px0", cap[4][0], 24'hFFFFFF);
    for (int i = 0; i < 12000 && !c_done; i++) begin
      @(posedge clk);
      #1;
    end
    chk("c_done", c_done, 1);
    chk("c_32_0", ccap[0], 24'hFFFFFF);
    chk("c_0_32", ccap[1], 24'hFFFFFF);
    chk("c_32_32", ccap[2], 24'h000000);
    chk("c_0_0", ccap[3], 24'h000000);
    chk("c_tuser0", c_tu0, 1);
    for (int i = 0; i < 8; i++) chk("b_gap", gaps[i], (i % 4 == 3) ? 0 : 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
